// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor cell: difference and borrow-out from x - y - b_in.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  logic w_xy_xor;

  assign w_xy_xor = x ^ y;
  assign d        = w_xy_xor ^ b_in;
  // Borrow when y exceeds x, or when the bits match and a borrow ripples in.
  assign b_out    = (~x & y) | (~w_xy_xor & b_in);

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow WIDTH-bit subtractor (x - y - c_in) with registered difference,
// borrow-out and valid.
module full_subtractor #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             c_out,
  output logic             out_valid
);

  logic [WIDTH:0]   w_borrow;
  logic [WIDTH-1:0] w_diff;

  logic [WIDTH-1:0] r_diff;
  logic             r_c_out;
  logic             r_out_valid;

  assign w_borrow[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .x     (x[i]),
      .y     (y[i]),
      .b_in  (w_borrow[i]),
      .d     (w_diff[i]),
      .b_out (w_borrow[i+1])
    );
  end

  // Result registers only load on valid; out_valid tracks in_valid every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff      <= '0;
      r_c_out     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_diff  <= w_diff;
        r_c_out <= w_borrow[WIDTH];
      end
    end
  end

  assign diff      = r_diff;
  assign c_out     = r_c_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random checks of full_subtractor at WIDTH = 1 and WIDTH = 8.
module tb_full_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH = 1 instance
  logic rst1, x1, y1, c1, v1;
  logic d1, co1, ov1;

  // WIDTH = 8 instance
  logic       rst8, c8, v8;
  logic [7:0] x8, y8, d8;
  logic       co8, ov8;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .x         (x1),
    .y         (y1),
    .c_in      (c1),
    .in_valid  (v1),
    .diff      (d1),
    .c_out     (co1),
    .out_valid (ov1)
  );

  full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst8),
    .x         (x8),
    .y         (y8),
    .c_in      (c8),
    .in_valid  (v8),
    .diff      (d8),
    .c_out     (co8),
    .out_valid (ov8)
  );

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; x1 = 1'b0; y1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    rst8 = 1'b1; x8 = 8'h00; y8 = 8'h00; c8 = 1'b0; v8 = 1'b0;
    step();
    step();
    checks++;
    if ({d1, co1, ov1} !== 3'b000) begin
      failures++;
      $display("FAIL reset_w1: got d=%b b=%b v=%b want d=0 b=0 v=0", d1, co1, ov1);
    end
    checks++;
    if ({d8, co8, ov8} !== 10'h000) begin
      failures++;
      $display("FAIL reset_w8: got d=%h b=%b v=%b want d=00 b=0 v=0", d8, co8, ov8);
    end
    rst1 = 1'b0;
    rst8 = 1'b0;
    step();
    checks++;
    if ({d1, co1, ov1} !== 3'b011) begin
      failures++;
      $display("FAIL reset_release_w1: got d=%b b=%b v=%b want d=0 b=1 v=1", d1, co1, ov1);
    end
  endtask

  task automatic test_truth_table();
    // Index = {x, y, c_in}; expected difference and borrow from the classic table.
    logic [7:0] exp_d;
    logic [7:0] exp_b;
    logic [2:0] idx;
    exp_d = 8'b1001_0110;
    exp_b = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {x1, y1, c1} = idx;
      v1 = 1'b1;
      step();
      checks++;
      if ({d1, co1, ov1} !== {exp_d[i], exp_b[i], 1'b1}) begin
        failures++;
        $display("FAIL truth_%b: got d=%b b=%b v=%b want d=%b b=%b v=1",
                 idx, d1, co1, ov1, exp_d[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_hold();
    x1 = 1'b1; y1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
    step();
    checks++;
    if ({d1, co1, ov1} !== 3'b101) begin
      failures++;
      $display("FAIL hold_capture: got d=%b b=%b v=%b want d=1 b=0 v=1", d1, co1, ov1);
    end
    x1 = 1'b0; y1 = 1'b1; c1 = 1'b1; v1 = 1'b0;
    step();
    step();
    checks++;
    if ({d1, co1, ov1} !== 3'b100) begin
      failures++;
      $display("FAIL hold_keep: got d=%b b=%b v=%b want d=1 b=0 v=0", d1, co1, ov1);
    end
  endtask

  task automatic test_wrap8();
    x8 = 8'h00; y8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
    step();
    checks++;
    if ({co8, d8, ov8} !== {1'b1, 8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL wrap_zero: got d=%h b=%b v=%b want d=ff b=1 v=1", d8, co8, ov8);
    end
    x8 = 8'h5A; y8 = 8'h3C; c8 = 1'b1;
    step();
    checks++;
    if ({co8, d8} !== {1'b0, 8'h1D}) begin
      failures++;
      $display("FAIL wrap_5a_3c: got d=%h b=%b want d=1d b=0", d8, co8);
    end
    x8 = 8'hFF; y8 = 8'h00; c8 = 1'b0;
    step();
    checks++;
    if ({co8, d8} !== {1'b0, 8'hFF}) begin
      failures++;
      $display("FAIL max_minus_zero: got d=%h b=%b want d=ff b=0", d8, co8);
    end
    x8 = 8'hA7; y8 = 8'hA7; c8 = 1'b0;
    step();
    checks++;
    if ({co8, d8} !== {1'b0, 8'h00}) begin
      failures++;
      $display("FAIL equal_ops: got d=%h b=%b want d=00 b=0", d8, co8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vx[5];
    logic [7:0] vy[5];
    logic       vc[5];
    logic [8:0] vexp[5];
    vx = '{8'h10, 8'h80, 8'h01, 8'hC3, 8'h00};
    vy = '{8'h20, 8'h7F, 8'h01, 8'h3C, 8'hFF};
    vc = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    vexp = '{9'h1F0, 9'h000, 9'h1FF, 9'h087, 9'h101};
    for (int i = 0; i < 5; i++) begin
      x8 = vx[i]; y8 = vy[i]; c8 = vc[i]; v8 = 1'b1;
      step();
      checks++;
      if ({co8, d8, ov8} !== {vexp[i], 1'b1}) begin
        failures++;
        $display("FAIL b2b_%0d: got {b,d}=%h v=%b want {b,d}=%h v=1", i, {co8, d8}, ov8, vexp[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    x8 = 8'h01; y8 = 8'h02; c8 = 1'b0; v8 = 1'b1; rst8 = 1'b1;
    step();
    checks++;
    if ({co8, d8, ov8} !== 10'h000) begin
      failures++;
      $display("FAIL midstream_reset: got d=%h b=%b v=%b want d=00 b=0 v=0", d8, co8, ov8);
    end
    rst8 = 1'b0;
    step();
    checks++;
    if ({co8, d8, ov8} !== {9'h1FF, 1'b1}) begin
      failures++;
      $display("FAIL after_reset: got d=%h b=%b v=%b want d=ff b=1 v=1", d8, co8, ov8);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    for (int i = 0; i < 1000; i++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      c8 = 1'($urandom);
      v8 = 1'b1;
      exp = {1'b0, x8} - {1'b0, y8} - {8'h00, c8};
      step();
      checks++;
      if ({co8, d8, ov8} !== {exp, 1'b1}) begin
        failures++;
        $display("FAIL random_%0d: x=%h y=%h c=%b got {b,d}=%h v=%b want {b,d}=%h v=1",
                 i, x8, y8, c8, {co8, d8}, ov8, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_wrap8();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
# full_subtractor

Parameterizable ripple-borrow full subtractor computing x − y − c_in with a registered difference and borrow-out. Used as a standalone arithmetic primitive in the EEE4019 combinational/sequential lab datapaths. The default WIDTH = 1 gives the classic single-bit full subtractor. Outputs are captured on the clock so the block drops into synchronous pipelines.

## Interface

One clock; reset is synchronous and active-high.

**Parameters**
- WIDTH, default 1: operand and difference width in bits; legal range ≥ 1.

**Ports**
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- x, input, WIDTH: minuend, unsigned.
- y, input, WIDTH: subtrahend, unsigned.
- c_in, input, 1: borrow-in, weight 1 at bit 0.
- in_valid, input, 1: qualifies x/y/c_in for this cycle.
- diff, output, WIDTH: registered (x − y − c_in) mod 2^WIDTH.
- c_out, output, 1: registered borrow-out; 1 when x < y + c_in (unsigned).
- out_valid, output, 1: registered copy of in_valid.

## Operation

- Per-bit cell, bit i, borrow b_i, with b_0 = c_in:
  - d_i = x_i ^ y_i ^ b_i
  - b_{i+1} = (~x_i & y_i) | (~(x_i ^ y_i) & b_i)
- Cells are chained LSB to MSB. c_out = b_WIDTH.
- Arithmetic identity: {c_out, diff} = ({1'b0,x} − {1'b0,y} − c_in) taken in WIDTH+1 bits; c_out is the sign/borrow bit.
- When in_valid = 1 at a rising edge: diff, c_out and out_valid ← results and 1.
- When in_valid = 0: diff and c_out hold their previous values; out_valid ← 0.
- No internal state beyond the output registers. No X-propagation masking is required; inputs are assumed known when in_valid = 1.

## Timing

- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Throughput is one operation per cycle.
- Reset: when rst = 1 at an edge, diff = 0, c_out = 0 and out_valid = 0, regardless of in_valid. Reset has priority over capture.
- Reset asserted mid-stream discards the operation sampled at that edge. The first valid result after reset deasserts appears 1 cycle after the first in_valid edge.
- The combinational path is the full ripple chain (WIDTH cells) from inputs to the register D pins. No multicycle constraint applies.
- Boundary cases:
  - x = y and c_in = 0 → diff = 0, c_out = 0.
  - x = 0, y = 0, c_in = 1 → diff = all ones, c_out = 1 (wrap-around).
  - x = max, y = 0, c_in = 0 → diff = max, c_out = 0.

## Structure

- No shared package is needed. WIDTH is a module parameter only.
- Sub-module full_subtractor_cell: purely combinational, 1-bit, ports x, y, b_in, d, b_out. Implements the per-bit equations above.
- Top level uses a generate loop instantiating WIDTH cells, a borrow chain wire of WIDTH+1 bits, and one always block for the output/valid registers with synchronous reset.

## Test plan

- Exhaustive truth table at WIDTH = 1. Drive in_valid = 1 and each (x, y, c_in), with outputs checked 1 cycle later:
  - 000 → d0 b0
  - 001 → d1 b1
  - 010 → d1 b1
  - 011 → d0 b1
  - 100 → d1 b0
  - 101 → d0 b0
  - 110 → d0 b0
  - 111 → d1 b1
- Reset at WIDTH = 1: hold rst = 1 with x = 0, y = 1, c_in = 1, in_valid = 1 → diff = 0, c_out = 0, out_valid = 0. Release rst → next edge gives diff = 0, c_out = 1, out_valid = 1.
- Hold behaviour: capture x = 1, y = 0, c_in = 0 (diff = 1, c_out = 0). Then drop in_valid and change the inputs → diff and c_out unchanged, out_valid = 0.
- WIDTH = 8 wrap-around: x = 0x00, y = 0x00, c_in = 1 → diff = 0xFF, c_out = 1. Then x = 0x5A, y = 0x3C, c_in = 1 → diff = 0x1D, c_out = 0.
- WIDTH = 8 borrow: x = 0x10, y = 0x20, c_in = 0 → diff = 0xF0, c_out = 1. Then back-to-back valid inputs every cycle → each result appears exactly 1 cycle later.
- Random WIDTH = 8, 1000 vectors: compare {c_out, diff} against a 9-bit reference subtraction with 1-cycle alignment.
